// File: rtl/bsg_manycore_mem_responder.sv
// bsg_manycore_mem_responder
//
// Single-port memory endpoint for one manycore link. It accepts forward
// request packets (word loads and byte-masked stores), services them from an
// internal word array, and returns exactly one reverse packet per request so
// that endpoint credits stay balanced. It is intended to stand in for a
// vcache/DRAM slice in small tests.
//
// Optional build macro: BSG_MANYCORE_MEM_RESPONDER_TRACE_EN
//   Defined:   prints one line per response handshake and one line when
//              error_o rises.
//   Undefined: no simulation output. Functional behaviour is the same in
//              both builds.
//
// Link layout (MSB first):
//   link_sif = {fwd_v, fwd_pkt, fwd_ready, rev_v, rev_pkt, rev_ready}
//   fwd_pkt  = {addr, op, mask, payload, load_id, src_y, src_x, dest_y, dest_x}
//   rev_pkt  = {pkt_type, data, load_id, y_cord, x_cord}
// Request ops:  0 = load, 1 = store, anything else is unsupported.
// Return types: 0 = load return, 1 = store return.
//
// FSM states:
//   state  | meaning
//   IDLE   | fwd ready asserted, waiting for a request
//   ACCESS | latched request is applied to the word array
//   RESP   | return packet presented on rev, held until rev ready

module bsg_manycore_mem_responder #(
  parameter int addr_width_p     = 16,
  parameter int data_width_p     = 32,
  parameter int x_cord_width_p   = 4,
  parameter int y_cord_width_p   = 4,
  parameter int load_id_width_p  = 5,
  parameter int mem_addr_width_p = 10,
  localparam int mask_width_lp     = data_width_p >> 3,
  localparam int fwd_pkt_width_lp  = addr_width_p + 2 + mask_width_lp + data_width_p
                                     + load_id_width_p
                                     + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int rev_pkt_width_lp  = 2 + data_width_p + load_id_width_p
                                     + x_cord_width_p + y_cord_width_p,
  localparam int link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  output logic                         error_o,
  output logic [31:0]                  req_count_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] op_load_lp    = 2'd0;
  localparam logic [1:0] op_store_lp   = 2'd1;
  localparam logic [1:0] rtn_load_lp   = 2'd0;
  localparam logic [1:0] rtn_store_lp  = 2'd1;

  localparam logic [data_width_p-1:0] bad_addr_data_lp = data_width_p'(32'hDEADBEEF);

  typedef struct packed {
    logic [addr_width_p-1:0]    addr;
    logic [1:0]                 op;
    logic [mask_width_lp-1:0]   mask;
    logic [data_width_p-1:0]    payload;
    logic [load_id_width_p-1:0] load_id;
    logic [y_cord_width_p-1:0]  src_y;
    logic [x_cord_width_p-1:0]  src_x;
    logic [y_cord_width_p-1:0]  dest_y;
    logic [x_cord_width_p-1:0]  dest_x;
  } fwd_pkt_s;

  typedef struct packed {
    logic [1:0]                 pkt_type;
    logic [data_width_p-1:0]    data;
    logic [load_id_width_p-1:0] load_id;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } rev_pkt_s;

  typedef struct packed {
    logic     fwd_v;
    fwd_pkt_s fwd_data;
    logic     fwd_ready;
    logic     rev_v;
    rev_pkt_s rev_data;
    logic     rev_ready;
  } link_sif_s;

  link_sif_s link_in;
  link_sif_s link_out;

  assign link_in    = link_sif_i;
  assign link_sif_o = link_out;

  // The mesh-side ready for our (unused) forward output and the whole
  // incoming reverse channel carry nothing this endpoint needs.
  logic unused_link_bits;
  assign unused_link_bits = ^{link_in.fwd_ready, link_in.rev_v, link_in.rev_data};

  logic [1:0] state_r, state_n;

  logic [addr_width_p-1:0]    addr_r;
  logic [1:0]                 op_r;
  logic [mask_width_lp-1:0]   mask_r;
  logic [data_width_p-1:0]    payload_r;
  logic [load_id_width_p-1:0] load_id_r;
  logic [y_cord_width_p-1:0]  src_y_r;
  logic [x_cord_width_p-1:0]  src_x_r;

  logic [1:0]                 rev_type_r;
  logic [data_width_p-1:0]    rev_data_r;
  logic                       error_r;
  logic [31:0]                req_count_r;

  logic [data_width_p-1:0]    mem_r [0:(1<<mem_addr_width_p)-1];

  logic                         fwd_ready;
  logic                         accept;
  logic                         rev_done;
  logic                         is_load;
  logic                         is_store;
  logic                         in_range;
  logic [mem_addr_width_p-1:0]  idx;
  logic                         dest_mismatch;
  logic                         access_err;

  // Ready depends on the reset pin too, so nothing is taken while reset is held.
  assign fwd_ready = (state_r == IDLE) && reset_n_i;
  assign accept    = link_in.fwd_v && fwd_ready;
  assign rev_done  = (state_r == RESP) && link_in.rev_ready;

  assign is_load  = (op_r == op_load_lp);
  assign is_store = (op_r == op_store_lp);
  assign idx      = addr_r[mem_addr_width_p-1:0];
  assign in_range = ((addr_r >> mem_addr_width_p) == '0);

  assign dest_mismatch = (link_in.fwd_data.dest_x != my_x_i)
                      || (link_in.fwd_data.dest_y != my_y_i);

  // Unsupported ops are errors regardless of address; loads/stores only when out of range.
  assign access_err = (state_r == ACCESS) && ((is_load || is_store) ? !in_range : 1'b1);

  // Next-state selection for the three-state request/response sequence.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (accept)   state_n = ACCESS;
      ACCESS:                state_n = RESP;
      RESP:    if (rev_done) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  // State register; reset discards any pending request or response.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  // Capture the accepted request; held untouched until the next accept.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_r    <= link_in.fwd_data.addr;
      op_r      <= link_in.fwd_data.op;
      mask_r    <= link_in.fwd_data.mask;
      payload_r <= link_in.fwd_data.payload;
      load_id_r <= link_in.fwd_data.load_id;
      src_y_r   <= link_in.fwd_data.src_y;
      src_x_r   <= link_in.fwd_data.src_x;
    end
  end

  // Byte-masked array write; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && (state_r == ACCESS) && is_store && in_range) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (mask_r[b]) mem_r[idx][8*b +: 8] <= payload_r[8*b +: 8];
      end
    end
  end

  // Build the return word during ACCESS so RESP can hold it constant.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rev_type_r <= rtn_load_lp;
      rev_data_r <= '0;
    end else if (state_r == ACCESS) begin
      rev_type_r <= is_load ? rtn_load_lp : rtn_store_lp;
      if (is_load) rev_data_r <= in_range ? mem_r[idx] : bad_addr_data_lp;
      else         rev_data_r <= '0;
    end
  end

  // Sticky error: bad address, unsupported op, or a request not addressed to us.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                              error_r <= 1'b0;
    else if ((accept && dest_mismatch) || access_err) error_r <= 1'b1;
  end

  // Accepted-request counter, free-running modulo 2^32.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  req_count_r <= '0;
    else if (accept) req_count_r <= req_count_r + 32'd1;
  end

  assign error_o     = error_r;
  assign req_count_o = req_count_r;

  // Drive the outgoing link: forward side only reports ready, reverse side
  // carries the return and always accepts (nothing arrives on it).
  always_comb begin
    link_out                   = '0;
    link_out.fwd_v             = 1'b0;
    link_out.fwd_ready         = fwd_ready;
    link_out.rev_v             = (state_r == RESP);
    link_out.rev_data.pkt_type = rev_type_r;
    link_out.rev_data.data     = rev_data_r;
    link_out.rev_data.load_id  = load_id_r;
    link_out.rev_data.y_cord   = src_y_r;
    link_out.rev_data.x_cord   = src_x_r;
    link_out.rev_ready         = 1'b1;
  end

`ifdef BSG_MANYCORE_MEM_RESPONDER_TRACE_EN
  logic error_q;

  // Trace each completed response and the first error after reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) error_q <= 1'b0;
    else            error_q <= error_r;
    if (reset_n_i && rev_done)
      $display("%0t mem_responder (%0d,%0d): op=%0d addr=%h data=%h load_id=%0d src=(%0d,%0d)",
               $time, my_x_i, my_y_i, op_r, addr_r, rev_data_r, load_id_r, src_x_r, src_y_r);
    if (reset_n_i && error_r && !error_q)
      $display("%0t mem_responder (%0d,%0d): error raised (op=%0d addr=%h)",
               $time, my_x_i, my_y_i, op_r, addr_r);
  end
`else
  // Default build is silent.
`endif

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Directed bench for bsg_manycore_mem_responder: latency, masking,
// back-pressure, error cases, reset mid-response and a random stream
// checked against a small reference model.

module tb_bsg_manycore_mem_responder;

  localparam int AW = 16;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int IW = 5;
  localparam int MW = 10;
  localparam int FW = AW + 2 + 4 + 32 + IW + 2 * (XW + YW);  // 75
  localparam int RW = 2 + 32 + IW + XW + YW;                 // 47
  localparam int LW = FW + RW + 4;                           // 126

  localparam logic [1:0] LD = 2'd0;
  localparam logic [1:0] ST = 2'd1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fwd_v;
  logic [FW-1:0] fwd_pkt;
  logic          rev_ready;
  logic [LW-1:0] link_i;
  logic [LW-1:0] link_o;
  logic [XW-1:0] my_x;
  logic [YW-1:0] my_y;
  logic          error;
  logic [31:0]   req_count;

  logic          fwd_ready_o;
  logic          rev_v_o;
  logic [RW-1:0] rev_pkt_o;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;
  int exp_count = 0;

  logic [RW-1:0] r;
  logic [RW-1:0] e;
  logic [31:0]   mdl [16];
  bit            vld [16];
  logic [3:0]    sa;
  logic [1:0]    sop;
  logic [3:0]    sm;
  logic [31:0]   sd;
  int            sst;

  always #5 clk = ~clk;

  assign link_i      = {fwd_v, fwd_pkt, 1'b1, 1'b0, {RW{1'b0}}, rev_ready};
  assign fwd_ready_o = link_o[RW+2];
  assign rev_v_o     = link_o[RW+1];
  assign rev_pkt_o   = link_o[RW:1];

  bsg_manycore_mem_responder #(
    .addr_width_p    (AW),
    .data_width_p    (32),
    .x_cord_width_p  (XW),
    .y_cord_width_p  (YW),
    .load_id_width_p (IW),
    .mem_addr_width_p(MW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .link_sif_i (link_i),
    .link_sif_o (link_o),
    .my_x_i     (my_x),
    .my_y_i     (my_y),
    .error_o    (error),
    .req_count_o(req_count)
  );

  function automatic logic [FW-1:0] req_d(input logic [AW-1:0] a, input logic [1:0] op,
                                          input logic [3:0] m, input logic [31:0] d,
                                          input logic [IW-1:0] id, input logic [YW-1:0] sy,
                                          input logic [XW-1:0] sx, input logic [YW-1:0] dy,
                                          input logic [XW-1:0] dx);
    return {a, op, m, d, id, sy, sx, dy, dx};
  endfunction

  function automatic logic [FW-1:0] req(input logic [AW-1:0] a, input logic [1:0] op,
                                        input logic [3:0] m, input logic [31:0] d,
                                        input logic [IW-1:0] id, input logic [YW-1:0] sy,
                                        input logic [XW-1:0] sx);
    return req_d(a, op, m, d, id, sy, sx, 4'd3, 4'd2);
  endfunction

  function automatic logic [RW-1:0] rsp(input logic [1:0] t, input logic [31:0] d,
                                        input logic [IW-1:0] id, input logic [YW-1:0] y,
                                        input logic [XW-1:0] x);
    return {t, d, id, y, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_txn(input logic [FW-1:0] pkt, input int stall, output logic [RW-1:0] rs);
    int n;
    n = 0;
    fwd_v = 1'b1;
    fwd_pkt = pkt;
    while (!fwd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", fwd_ready_o, 1);
    @(posedge clk); #1 fwd_v = 1'b0;
    exp_count++;
    @(negedge clk); chk("lat_access_v", rev_v_o, 0);
    @(negedge clk); chk("lat_resp_v", rev_v_o, 1);
    rs = rev_pkt_o;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_hold", {rev_v_o, rev_pkt_o}, {1'b1, rs});
    end
    rev_ready = 1'b1;
    @(posedge clk); #1 rev_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    exp_count = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    fwd_v = 1'b0;
    fwd_pkt = '0;
    rev_ready = 1'b0;
    my_x = 4'd2;
    my_y = 4'd3;
    for (int i = 0; i < 16; i++) vld[i] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fwd_ready", fwd_ready_o, 0);
    chk("rst_rev_v", rev_v_o, 0);
    chk("rst_error", error, 0);
    chk("rst_count", req_count, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", fwd_ready_o, 1);
    chk("static_outs", {link_o[LW-1], link_o[0]}, 2'b01);

    // Store then load
    do_txn(req(16'd5, ST, 4'hF, 32'hCAFEF00D, 5'd3, 4'd0, 4'd1), 0, r);
    chk("st_rsp", r, rsp(2'd1, 32'h0, 5'd3, 4'd0, 4'd1));
    do_txn(req(16'd5, LD, 4'h0, 32'h0, 5'd7, 4'd1, 4'd0), 0, r);
    chk("ld_rsp", r, rsp(2'd0, 32'hCAFEF00D, 5'd7, 4'd1, 4'd0));
    chk("count_2", req_count, 2);
    chk("err_clean", error, 0);

    // Masked store
    do_txn(req(16'd0, ST, 4'hF, 32'hFFFFFFFF, 5'd1, 4'd0, 4'd1), 0, r);
    do_txn(req(16'd0, ST, 4'b0101, 32'h11223344, 5'd2, 4'd0, 4'd1), 1, r);
    chk("mask_st_rsp", r, rsp(2'd1, 32'h0, 5'd2, 4'd0, 4'd1));
    do_txn(req(16'd0, LD, 4'h0, 32'h0, 5'd4, 4'd2, 4'd3), 0, r);
    chk("mask_ld_rsp", r, rsp(2'd0, 32'hFF22FF44, 5'd4, 4'd2, 4'd3));

    // Back-pressure with a queued request
    do_reset();
    fwd_v = 1'b1;
    fwd_pkt = req(16'd5, LD, 4'h0, 32'h0, 5'd9, 4'd1, 4'd1);
    @(posedge clk); #1;
    fwd_pkt = req(16'd0, LD, 4'h0, 32'h0, 5'd10, 4'd1, 4'd2);
    @(negedge clk);
    chk("bp_access_v", rev_v_o, 0);
    chk("bp_access_ready", fwd_ready_o, 0);
    @(negedge clk);
    chk("bp_resp_v", rev_v_o, 1);
    r = rev_pkt_o;
    chk("bp_rsp", r, rsp(2'd0, 32'hCAFEF00D, 5'd9, 4'd1, 4'd1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {rev_v_o, rev_pkt_o}, {1'b1, r});
      chk("bp_fwd_ready", fwd_ready_o, 0);
    end
    rev_ready = 1'b1;
    @(posedge clk); #1 rev_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_hs", fwd_ready_o, 1);
    chk("bp_v_after_hs", rev_v_o, 0);
    @(posedge clk); #1 fwd_v = 1'b0;
    @(negedge clk);
    chk("bp_q_accepted", fwd_ready_o, 0);
    chk("bp_count", req_count, 2);
    @(negedge clk);
    chk("bp_q_v", rev_v_o, 1);
    chk("bp_q_rsp", rev_pkt_o, rsp(2'd0, 32'hFF22FF44, 5'd10, 4'd1, 4'd2));
    rev_ready = 1'b1;
    @(posedge clk); #1 rev_ready = 1'b0;
    @(negedge clk);
    exp_count = 2;

    // Out-of-range and unsupported ops
    do_txn(req(16'd1024, LD, 4'h0, 32'h0, 5'd11, 4'd0, 4'd1), 0, r);
    chk("oor_ld_rsp", r, rsp(2'd0, 32'hDEADBEEF, 5'd11, 4'd0, 4'd1));
    chk("oor_err", error, 1);
    do_txn(req(16'd1029, ST, 4'hF, 32'h12345678, 5'd12, 4'd0, 4'd1), 0, r);
    chk("oor_st_rsp", r, rsp(2'd1, 32'h0, 5'd12, 4'd0, 4'd1));
    do_txn(req(16'd5, LD, 4'h0, 32'h0, 5'd13, 4'd0, 4'd1), 0, r);
    chk("oor_st_dropped", r, rsp(2'd0, 32'hCAFEF00D, 5'd13, 4'd0, 4'd1));
    chk("err_sticky", error, 1);
    do_txn(req(16'd1023, ST, 4'hF, 32'h0BADCAFE, 5'd14, 4'd0, 4'd1), 0, r);
    do_txn(req(16'd1023, LD, 4'h0, 32'h0, 5'd15, 4'd0, 4'd1), 0, r);
    chk("top_word_ld", r, rsp(2'd0, 32'h0BADCAFE, 5'd15, 4'd0, 4'd1));
    do_txn(req(16'd5, 2'd2, 4'hF, 32'h55555555, 5'd16, 4'd0, 4'd1), 0, r);
    chk("bad_op_rsp", r, rsp(2'd1, 32'h0, 5'd16, 4'd0, 4'd1));
    do_txn(req(16'd5, LD, 4'h0, 32'h0, 5'd17, 4'd0, 4'd1), 0, r);
    chk("bad_op_no_write", r, rsp(2'd0, 32'hCAFEF00D, 5'd17, 4'd0, 4'd1));
    chk("count_after_err", req_count, exp_count);

    // Reset while a response is pending
    do_txn(req(16'd7, ST, 4'hF, 32'hA5A50001, 5'd18, 4'd0, 4'd1), 0, r);
    fwd_v = 1'b1;
    fwd_pkt = req(16'd7, LD, 4'h0, 32'h0, 5'd19, 4'd0, 4'd1);
    @(posedge clk); #1 fwd_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_v", rev_v_o, 1);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    exp_count = 0;
    chk("mid_rst_v", rev_v_o, 0);
    chk("mid_rst_count", req_count, 0);
    chk("mid_rst_err", error, 0);
    chk("mid_rst_ready", fwd_ready_o, 1);
    do_txn(req(16'd7, LD, 4'h0, 32'h0, 5'd20, 4'd0, 4'd1), 0, r);
    chk("mem_kept", r, rsp(2'd0, 32'hA5A50001, 5'd20, 4'd0, 4'd1));
    chk("mid_rst_count1", req_count, 1);

    // Request addressed elsewhere: serviced, but flags an error
    do_txn(req_d(16'd7, LD, 4'h0, 32'h0, 5'd21, 4'd0, 4'd1, 4'd3, 4'd5), 0, r);
    chk("dest_rsp", r, rsp(2'd0, 32'hA5A50001, 5'd21, 4'd0, 4'd1));
    chk("dest_err", error, 1);

    // Random stream against a reference model
    do_reset();
    for (int i = 0; i < 100; i++) begin
      sa  = 4'($urandom_range(0, 15));
      sop = ($urandom_range(0, 1) == 0) ? LD : ST;
      if (!vld[sa]) sop = ST;
      sm  = (sop == ST) ? (vld[sa] ? 4'($urandom_range(0, 15)) : 4'hF) : 4'h0;
      sd  = $urandom;
      sst = $urandom_range(0, 3);
      if (sop == LD) e = rsp(2'd0, mdl[sa], 5'(i), 4'(i % 3), 4'(i % 5));
      else           e = rsp(2'd1, 32'h0, 5'(i), 4'(i % 3), 4'(i % 5));
      do_txn(req(16'd100 + 16'(sa), sop, sm, sd, 5'(i), 4'(i % 3), 4'(i % 5)), sst, r);
      chk("stream_rsp", r, e);
      if (sop == ST) begin
        for (int b = 0; b < 4; b++) if (sm[b]) mdl[sa][8*b +: 8] = sd[8*b +: 8];
        vld[sa] = 1'b1;
      end
    end
    chk("stream_count", req_count, 100);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_mem_responder.md
# bsg_manycore_mem_responder

Single-port memory endpoint that terminates one manycore link (e.g. a south-edge cache slot or a host IO port) and answers forward-network request packets with reverse-network return packets. It stands in for a vcache/DRAM slice in small tests. It accepts word loads and masked stores, services them from an internal word array, and returns one response per request so that endpoint credits stay balanced.

## Interface
- addr_width_p, "inv": packet address width, in words.
- data_width_p, 32: data word width; must be 32.
- x_cord_width_p, "inv": X coordinate width.
- y_cord_width_p, "inv": Y coordinate width.
- load_id_width_p, "inv": load id width.
- mem_addr_width_p, 10: log2 of the word count of the internal array.
- link_sif_width_lp, derived: `bsg_manycore_link_sif_width(addr_width_p,data_width_p,x_cord_width_p,y_cord_width_p)`.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset; one clock.
- link_sif_i  in  link_sif_width_lp  link from the mesh: forward requests in, reverse ready in.
- link_sif_o  out  link_sif_width_lp  link to the mesh: forward ready out, reverse returns out.
- my_x_i  in  x_cord_width_p  this endpoint's X coordinate.
- my_y_i  in  y_cord_width_p  this endpoint's Y coordinate.
- error_o  out  1  sticky error flag; set by an out-of-range address or an unsupported op.
- req_count_o  out  32  count of accepted requests; wraps at 2^32.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- In IDLE, fwd ready is 1. When fwd v & ready, the packet is latched (addr, op, mask, payload, src_x, src_y, load_id) and the FSM goes to ACCESS. req_count_o increments.
- In ACCESS:
  - idx = addr[mem_addr_width_p-1:0].
  - in_range = (addr >> mem_addr_width_p) == 0.
  - Load with in_range: the array is read and the word is captured.
  - Store with in_range: only the bytes whose mask bit is set are written.
  - Out-of-range load returns 32'hDEADBEEF. Out-of-range store is dropped. Either case sets error_o.
  - Any op other than load or store returns data 0 and sets error_o.
  - The FSM always goes to RESP.
- In RESP, rev v = 1 and the return packet is:
  - pkt_type: load for loads, store for stores and unsupported ops.
  - data: the read or error data; 0 for stores.
  - load_id: echoed from the request.
  - dest: the request's src_x/src_y.
  - The packet is held stable until rev ready. On the handshake the FSM goes to IDLE.
- Requests whose dest differs from my_x_i/my_y_i are still serviced, and error_o is set.
- Every forward link pin other than ready is input-only. Unused reverse-direction pins (rev-side ready outputs) are driven to 1.

## Timing
- Reset (reset_n_i = 0 at a clk_i edge) has the following effect at that edge:
  - state = IDLE
  - fwd ready = 0 during reset, 1 from the first cycle after reset
  - rev v = 0
  - error_o = 0
  - req_count_o = 0
  - Array contents are not cleared.
- Latency: request accepted at edge t, array accessed in cycle t+1, rev v = 1 from cycle t+2.
- Issue rate: the next request can be accepted no earlier than the cycle after the response handshake. Minimum is 3 cycles per request.
- Fwd ready is 0 in ACCESS and RESP. A request that arrives while busy stalls upstream and is not lost.
- Rev back-pressure: the response stays in RESP indefinitely with constant packet contents.
- Reset mid-operation: any pending request or response is discarded and rev v drops in the next cycle. Credits are recovered by the mesh-wide reset.
- Store followed immediately by a load to the same word: the load observes the store. There is no bypass hazard because accesses are serialized.
- req_count_o: 32'hFFFFFFFF + 1 wraps to 0.

## Configuration
- BSG_MANYCORE_MEM_RESPONDER_TRACE_EN defined: on each response handshake, print one line with: time, my_x/my_y, op, word address, data, load_id, src_x/src_y. On error_o rising, print one error line.
- Not defined: no simulation output. Functional behaviour is identical in both builds.

## Test plan
- Store then load: store 32'hCAFEF00D mask 4'hF at addr 5, then load addr 5. Expect a store return followed by a load return with data CAFEF00D and load_id echoed. rev v rises exactly 2 cycles after each accept.
- Masked store: store 32'h11223344 at addr 0 with mask 4'b0101 over 32'hFFFFFFFF. A load of addr 0 returns 32'hFF22FF44.
- Back-pressure: hold rev ready = 0 for 10 cycles. The response stays stable, fwd ready stays 0 throughout, a queued request is accepted the cycle after the handshake, and req_count_o = 2.
- Out of range: with mem_addr_width_p = 10, load addr 1024. The return carries 32'hDEADBEEF, error_o = 1, and error_o stays 1 through later good requests.
- Reset mid-RESP: deassert reset_n_i for one cycle while rev v = 1. Next cycle rev v = 0, req_count_o = 0, error_o = 0, and a load returns the data stored before the reset.
- Streaming: 100 random loads and stores to random in-range addresses with random rev stalls. Every return matches a scoreboard model in order, and req_count_o = 100.
